byte_serializer: RTL

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/byte_serializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - parallel word to serial bit stream with optional inter-word gap and flush
module byte_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [IDX_W-1:0] bit_idx;
    logic [3:0]       gap_cnt;
    logic             ready_en;
    logic             last_bit;
    logic             accept;

    // ready_en holds din_ready low until the first clock edge after reset releases
    assign last_bit  = (state == S_SHIFT) && (bit_idx == IDX_W'(WIDTH - 1));
    assign din_ready = ready_en && !flush &&
                       ((state == S_IDLE) || (last_bit && (GAP == 0)));
    assign accept    = din_valid && din_ready;
    assign busy      = (state != S_IDLE);

    // The outgoing bit always sits at the emitting end of sreg
    assign sreg_next = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            sreg       <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            word_cnt   <= 16'd0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                state      <= S_IDLE;
                sreg       <= '0;
                bit_idx    <= '0;
                gap_cnt    <= '0;
                dout       <= 1'b0;
                dout_valid <= 1'b0;
                // the final bit is already on dout, so that word still counts
                if (last_bit) begin
                    word_cnt <= word_cnt + 16'd1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            state      <= S_SHIFT;
                            sreg       <= din;
                            bit_idx    <= '0;
                            dout       <= head_bit(din);
                            dout_valid <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (last_bit) begin
                            word_cnt <= word_cnt + 16'd1;
                            if (accept) begin
                                sreg       <= din;
                                bit_idx    <= '0;
                                dout       <= head_bit(din);
                                dout_valid <= 1'b1;
                            end else begin
                                state      <= (GAP > 0) ? S_GAP : S_IDLE;
                                gap_cnt    <= (GAP > 0) ? 4'(GAP - 1) : 4'd0;
                                sreg       <= '0;
                                bit_idx    <= '0;
                                dout       <= 1'b0;
                                dout_valid <= 1'b0;
                            end
                        end else begin
                            sreg    <= sreg_next;
                            bit_idx <= bit_idx + IDX_W'(1);
                            dout    <= head_bit(sreg_next);
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == 4'd0) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
